frame_marker_inserter: RTL and testbench



---
 rtl/interleaver_pkg.sv | 30 +++
 rtl/marker_prn_gen.sv | 53 +++++
 rtl/frame_marker_inserter.sv | 206 ++++++++++++++++++++
 tb/tb_frame_marker_inserter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interleaver_pkg.sv
// -----------------------------------------------------------------------------
// interleaver_pkg
// Shared definitions for the interleaver output path:
//   - frame_marker_inserter FSM state encoding
//   - default attached sync marker (ASM)
//   - CCSDS pseudo-randomizer constants and single-bit step helper
// Optional build macro consumed elsewhere: MARKER_SCRAMBLE_EN.
// -----------------------------------------------------------------------------
package interleaver_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSync    = 2'd1,
    StPayload = 2'd2
  } fmi_state_e;

  localparam logic [31:0] AsmDefault = 32'h1ACFFC1D;

  // h(x) = x^8 + x^7 + x^5 + x^3 + 1. The register holds the next eight sequence
  // bits with the oldest in bit 7, so the x^7, x^5, x^3 and x^0 terms land on
  // bits 0, 2, 4 and 7.
  localparam logic [7:0] PrnTaps = 8'h95;
  localparam logic [7:0] PrnSeed = 8'hFF;

  // Advance the randomizer by one bit; bit 7 of the argument is the bit consumed.
  function automatic logic [7:0] prn_next(input logic [7:0] r);
    return {r[6:0], ^(r & PrnTaps)};
  endfunction

endpackage

// File: rtl/marker_prn_gen.sv
// -----------------------------------------------------------------------------
// marker_prn_gen
// CCSDS pseudo-randomizer producing width sequence bits per step. prn_o shows
// the bits for the current beat, MSB = earliest sequence bit. Only instantiated
// when MARKER_SCRAMBLE_EN is defined.
// Ports:
//   clk          clock
//   rst          asynchronous reset, active-high (loads the seed)
//   seed_load_i  reload the seed on the next edge (has priority)
//   advance_i    consume width bits on the next edge
//   prn_o        current width-bit sequence chunk
// -----------------------------------------------------------------------------
module marker_prn_gen
  import interleaver_pkg::*;
#(
  parameter int unsigned width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load_i,
  input  logic             advance_i,
  output logic [width-1:0] prn_o
);

  logic [7:0] lfsr_q, lfsr_d, lfsr_step;

  always_comb begin
    lfsr_step = lfsr_q;
    prn_o     = '0;
    for (int unsigned i = 0; i < width; i++) begin
      prn_o[width-1-i] = lfsr_step[7];
      lfsr_step        = prn_next(lfsr_step);
    end
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_load_i) begin
      lfsr_d = PrnSeed;
    end else if (advance_i) begin
      lfsr_d = lfsr_step;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= PrnSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/frame_marker_inserter.sv
// -----------------------------------------------------------------------------
// frame_marker_inserter
// Prepends a fixed attached sync marker (sync_len chunks of width bits, MSB
// first) to every tlast-delimited block from the interleaver and forwards the
// payload. All m_axis_* outputs are registered.
// Optional macro MARKER_SCRAMBLE_EN: payload beats (never marker beats) are XORed
// with the CCSDS pseudo-randomizer, reseeded at the start of every payload.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   s_axis_tdata/tvalid/tlast payload input, s_axis_tready back to interleaver
//   m_axis_tdata/tvalid       marker or payload beat
//   m_axis_tuser              first marker beat of a frame
//   m_axis_tlast              last payload beat of a frame
//   m_axis_tready             downstream ready
//   frame_cnt                 completed frames emitted (wraps)
// -----------------------------------------------------------------------------
module frame_marker_inserter
  import interleaver_pkg::*;
#(
  parameter int unsigned                  width     = 1,
  parameter int unsigned                  sync_len  = 32,
  parameter logic [width*sync_len-1:0]    sync_word = AsmDefault,
  parameter int unsigned                  cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [width-1:0]     s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  output logic [width-1:0]     m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tuser,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic [cnt_width-1:0] frame_cnt
);

  localparam int unsigned     CntW    = (sync_len > 1) ? $clog2(sync_len) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(sync_len - 1);

  fmi_state_e state_q, state_d;
  logic [CntW-1:0]      mcnt_q, mcnt_d;
  logic [width-1:0]     tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tuser_q, tuser_d;
  logic                 tlast_q, tlast_d;
  logic [cnt_width-1:0] frame_cnt_q;

  logic             slot_free;
  logic             s_ready;
  logic             s_hs;
  logic [width-1:0] payload;

  // Chunk 0 is the most significant width bits of the marker.
  function automatic logic [width-1:0] marker_chunk(input logic [CntW-1:0] idx);
    return sync_word[(int'(sync_len) - 1 - int'(idx)) * int'(width) +: width];
  endfunction

  assign slot_free = ~tvalid_q | m_axis_tready;
  assign s_hs      = s_ready & s_axis_tvalid;

`ifdef MARKER_SCRAMBLE_EN
  logic [width-1:0] prn;
  logic             seed_load;

  // Reseed on the edge that enters PAYLOAD so every frame restarts the sequence.
  assign seed_load = (state_d == StPayload) && (state_q != StPayload);

  marker_prn_gen #(
    .width(width)
  ) u_prn (
    .clk        (clk),
    .rst        (rst),
    .seed_load_i(seed_load),
    .advance_i  (s_hs),
    .prn_o      (prn)
  );

  assign payload = s_axis_tdata ^ prn;
`else
  assign payload = s_axis_tdata;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    case (state_q)
      StIdle: begin
        if (s_axis_tvalid && slot_free) begin
          if (sync_len == 1) begin
            state_d = StPayload;
            mcnt_d  = '0;
          end else begin
            state_d = StSync;
            mcnt_d  = CntW'(1);
          end
        end
      end
      StSync: begin
        if (slot_free) begin
          if (mcnt_q == LastIdx) begin
            state_d = StPayload;
            mcnt_d  = '0;
          end else begin
            mcnt_d = mcnt_q + CntW'(1);
          end
        end
      end
      StPayload: begin
        if (s_hs && s_axis_tlast) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        mcnt_d  = '0;
      end
    endcase
  end

  // Output logic: next value of the output register and the input ready.
  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    s_ready  = 1'b0;
    case (state_q)
      StIdle: begin
        if (s_axis_tvalid && slot_free) begin
          tdata_d  = marker_chunk('0);
          tvalid_d = 1'b1;
          tuser_d  = 1'b1;
          tlast_d  = 1'b0;
        end else if (slot_free) begin
          tvalid_d = 1'b0;
        end
      end
      StSync: begin
        if (slot_free) begin
          tdata_d  = marker_chunk(mcnt_q);
          tvalid_d = 1'b1;
          tuser_d  = 1'b0;
          tlast_d  = 1'b0;
        end
      end
      StPayload: begin
        s_ready = slot_free;
        if (slot_free && s_axis_tvalid) begin
          tdata_d  = payload;
          tvalid_d = 1'b1;
          tuser_d  = 1'b0;
          tlast_d  = s_axis_tlast;
        end else if (slot_free) begin
          tvalid_d = 1'b0;
        end
      end
      default: begin
        tvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (tvalid_q && m_axis_tready && tlast_q) begin
      frame_cnt_q <= frame_cnt_q + cnt_width'(1);
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_frame_marker_inserter.sv
// -----------------------------------------------------------------------------
// tb_frame_marker_inserter
// Scoreboard bench: each frame's expected output (marker chunks then payload,
// optionally randomized when MARKER_SCRAMBLE_EN is defined) is queued when the
// frame is issued; a monitor compares every presented output beat against the
// queue head and pops on handshake.
// -----------------------------------------------------------------------------
module tb_frame_marker_inserter;

  localparam int W  = 1;
  localparam int SL = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [CW-1:0] frame_cnt;

  frame_marker_inserter #(
    .width    (W),
    .sync_len (SL),
    .sync_word(32'h1ACFFC1D),
    .cnt_width(CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         user;
    logic         last;
  } beat_t;

  beat_t        exp_q[$];
  logic [W-1:0] pl[$];
  bit           seq[$];
  int           tuser_cyc[$];
  logic [W*SL-1:0] asm_v;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int hs_cnt = 0;
  int ready_mode = 0;
  int rand_gaps = 0;
  int exp_frames = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Downstream ready: 0 = always ready, 1 = toggle each cycle, 2 = random.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: any valid beat must equal the queue head, held or not.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat got data=%h user=%b last=%b required no beat",
                 m_axis_tdata, m_axis_tuser, m_axis_tlast);
      end else begin
        if (m_axis_tdata !== exp_q[0].data || m_axis_tuser !== exp_q[0].user ||
            m_axis_tlast !== exp_q[0].last) begin
          errors++;
          $display("FAIL out_beat@%0d got data=%h user=%b last=%b required data=%h user=%b last=%b",
                   cycle, m_axis_tdata, m_axis_tuser, m_axis_tlast,
                   exp_q[0].data, exp_q[0].user, exp_q[0].last);
        end
        if (m_axis_tready) begin
          void'(exp_q.pop_front());
          hs_cnt++;
          if (m_axis_tuser) tuser_cyc.push_back(cycle);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_tuser"},  32'(m_axis_tuser),  32'd0);
    chk({tag, "_tlast"},  32'(m_axis_tlast),  32'd0);
    chk({tag, "_tdata"},  32'(m_axis_tdata),  32'd0);
    chk({tag, "_sready"}, 32'(s_axis_tready), 32'd0);
    chk({tag, "_fcnt"},   32'(frame_cnt),     32'd0);
  endtask

  // Expected output of one frame: marker MSB-first, then (randomized) payload.
  task automatic push_frame();
    beat_t        b;
    logic [W-1:0] d;
    for (int k = 0; k < SL; k++) begin
      b.data = asm_v[(SL-1-k)*W +: W];
      b.user = (k == 0);
      b.last = 1'b0;
      exp_q.push_back(b);
    end
    for (int j = 0; j < pl.size(); j++) begin
      d = pl[j];
`ifdef MARKER_SCRAMBLE_EN
      for (int i = 0; i < W; i++) d[W-1-i] = d[W-1-i] ^ seq[j*W+i];
`endif
      b.data = d;
      b.user = 1'b0;
      b.last = (j == pl.size() - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_frame(input int gap_pos, input int gap_len);
    bit acc;
    int n;
    for (int j = 0; j < pl.size(); j++) begin
      if (j == gap_pos && gap_len > 0) begin
        s_axis_tvalid = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end else if (rand_gaps != 0 && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pl[j];
      s_axis_tlast  = (j == pl.size() - 1);
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 5000) begin
        @(negedge clk);
        acc = s_axis_tready;
        n++;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout got no s_axis_tready required accept of beat %0d", j);
        return;
      end
    end
  endtask

  task automatic send_frame(input int gap_pos, input int gap_len);
    push_frame();
    drive_frame(gap_pos, gap_len);
    exp_frames++;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
  endtask

  initial begin
    int base;
    int n;
    int d;
    asm_v = 32'h1ACFFC1D;
    // CCSDS sequence straight from the recurrence s[n+8] = s[n+7]^s[n+5]^s[n+3]^s[n].
    for (int i = 0; i < 8; i++) seq.push_back(1'b1);
    for (int i = 0; seq.size() < 4096; i++) seq.push_back(seq[i+7] ^ seq[i+5] ^ seq[i+3] ^ seq[i]);

    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    #1;
    chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic frame.
    pl.delete();
    foreach (pl[i]) pl.delete(i);
    {pl[0], pl[1], pl[2], pl[3]} = 4'b1011;
    {pl[4], pl[5], pl[6], pl[7]} = 4'b0010;
    send_frame(-1, 0);
    s_axis_tvalid = 1'b0;
    wait_drain("basic");

    // Back-to-back, s_axis_tvalid held high between frames.
    tuser_cyc.delete();
    for (int f = 0; f < 2; f++) begin
      pl.delete();
      for (int j = 0; j < 4; j++) pl.push_back(W'($urandom));
      send_frame(-1, 0);
    end
    s_axis_tvalid = 1'b0;
    wait_drain("b2b");
    chk("b2b_frames_seen", 32'(tuser_cyc.size()), 32'd2);
    if (tuser_cyc.size() == 2) begin
      d = tuser_cyc[1] - tuser_cyc[0];
      checks++;
      if (d != SL + 4 && d != SL + 5) begin
        errors++;
        $display("FAIL b2b_period got %0d required %0d or %0d", d, SL + 4, SL + 5);
      end
    end

    // Backpressure: same frame as the basic case under toggling ready.
    ready_mode = 1;
    pl.delete();
    {pl[0], pl[1], pl[2], pl[3]} = 4'b1011;
    {pl[4], pl[5], pl[6], pl[7]} = 4'b0010;
    send_frame(-1, 0);
    s_axis_tvalid = 1'b0;
    wait_drain("bp");

    // Input bubble of 3 cycles mid-payload.
    ready_mode = 0;
    pl.delete();
    for (int j = 0; j < 8; j++) pl.push_back(W'($urandom));
    send_frame(4, 3);
    s_axis_tvalid = 1'b0;
    wait_drain("bubble");

    // Random traffic; the first frame is a single payload beat.
    ready_mode = 2;
    rand_gaps  = 1;
    for (int f = 0; f < 6; f++) begin
      pl.delete();
      n = (f == 0) ? 1 : int'($urandom_range(1, 12));
      for (int j = 0; j < n; j++) pl.push_back(W'($urandom));
      send_frame(-1, 0);
      if ($urandom_range(0, 1) == 0) s_axis_tvalid = 1'b0;
    end
    s_axis_tvalid = 1'b0;
    rand_gaps = 0;
    wait_drain("random");

    // 255 zero payload bits: exposes the randomizer sequence when enabled.
    ready_mode = 0;
    pl.delete();
    for (int j = 0; j < 255; j++) pl.push_back('0);
    send_frame(-1, 0);
    s_axis_tvalid = 1'b0;
    wait_drain("zeros");

    // Reset after 10 marker beats, then a fresh 4-beat frame.
    pl.delete();
    for (int j = 0; j < 4; j++) pl.push_back(W'($urandom));
    push_frame();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = '1;
    s_axis_tlast  = 1'b0;
    base = hs_cnt;
    n = 0;
    while (hs_cnt - base < 10 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("mid_reset_markers_seen", 32'(hs_cnt - base), 32'd10);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    s_axis_tvalid = 1'b0;
    exp_frames = 0;
    chk_reset_outputs("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("held_reset");
    rst = 1'b0;
    send_frame(-1, 0);
    s_axis_tvalid = 1'b0;
    wait_drain("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
